// File: rtl/cla_pkg.sv
// Shared definitions for the multi-word CLA sequencer.
//   SLICE_W  - width of one carry_look_ahead_adder pass
//   state_t  - controller states (S_IDLE, S_RUN, S_DONE)
//   nslice() - number of nibble passes needed for a given operand width
package cla_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int unsigned nslice(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla_multiword_add_ctrl_if.sv
// Request/result bundle for cla_multiword_add_ctrl.
//   master: start, sub, a, b, cin out; ready, busy, done, sum, cout, ovf in
//   slave : the mirror image, used by the sequencer
interface cla_multiword_add_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  ready, busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output ready, busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/carry_look_ahead_adder.sv
// 4-bit carry-look-ahead adder slice.
//   A, B : 4-bit operands
//   Cin  : carry in
//   Sum  : 4-bit sum
//   Cout : carry out of bit 3
module carry_look_ahead_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Every carry is expanded from Cin directly; no ripple between bits.
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & Cin);

    assign Sum  = p ^ c[3:0];
    assign Cout = c[4];
endmodule

// File: rtl/cla_multiword_add_ctrl.sv
// WIDTH-bit add/subtract built by time-multiplexing one 4-bit CLA slice,
// least-significant nibble first.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - slave side of cla_multiword_add_ctrl_if:
//          start/sub/a/b/cin request, ready/busy/done status,
//          sum/cout/ovf result registers
// WIDTH must be a multiple of 4 and at least 8.
module cla_multiword_add_ctrl
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    cla_multiword_add_ctrl_if.slave   bus
);
    localparam int unsigned NSLICE = nslice(WIDTH);
    localparam int unsigned IDX_W  = $clog2(NSLICE);
    localparam int unsigned MSB    = WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             state_q, state_d;
    logic               accept;
    logic [WIDTH-1:0]   a_r, b_r, sum_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q, cout_q, ovf_q;

    logic [SLICE_W-1:0] s_a, s_b, s_sum;
    logic               s_cout;

    assign s_a = a_r[SLICE_W*idx_q +: SLICE_W];
    assign s_b = b_r[SLICE_W*idx_q +: SLICE_W];

    carry_look_ahead_adder u_slice (
        .A    (s_a),
        .B    (s_b),
        .Cin  (carry_q),
        .Sum  (s_sum),
        .Cout (s_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    accept  = 1'b1;
                end
            end
            S_RUN: begin
                if (idx_q == LAST_IDX) state_d = S_DONE;
            end
            S_DONE: begin
                // A start here chains straight into the next operation.
                if (bus.start) begin
                    state_d = S_RUN;
                    accept  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_r     <= bus.a;
            // Subtract as A + ~B + 1; the +1 enters through the first carry.
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            idx_q   <= '0;
            sum_q   <= '0;
        end else if (state_q == S_RUN) begin
            sum_q[SLICE_W*idx_q +: SLICE_W] <= s_sum;
            carry_q <= s_cout;
            idx_q   <= idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
                cout_q <= s_cout;
                ovf_q  <= (a_r[MSB] == b_r[MSB]) && (s_sum[SLICE_W-1] != a_r[MSB]);
            end
        end
    end

    // Status is decoded from registered state only, so start never reaches these.
    assign bus.ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign bus.busy  = (state_q == S_RUN);
    assign bus.done  = (state_q == S_DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_cla_multiword_add_ctrl.sv
// Directed self-checking bench for cla_multiword_add_ctrl (WIDTH=16).
module tb_cla_multiword_add_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;
    logic saw_done;

    cla_multiword_add_ctrl_if #(.WIDTH(16)) bus ();

    cla_multiword_add_ctrl #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start=1 and pass the accepting edge.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.sub   = sub;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Counts edges from the accepting edge (=1) until done is seen, bounded.
    task automatic wait_done(input int already, output int n);
        n = already;
        while (bus.done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic check_result(input string tag, input int n, input logic [15:0] esum,
                                input logic ecout, input logic eovf);
        chk({tag, "_lat"}, 32'(n), 32'd5);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(esum));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ecout));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eovf));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.cin   = 1'b0;

        // Reset held two cycles with start asserted.
        step();
        step();
        chk("rst_sum", 32'(bus.sum), 32'h0);
        chk("rst_cout", 32'(bus.cout), 32'h0);
        chk("rst_ovf", 32'(bus.ovf), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ready", 32'(bus.ready), 32'h1);
        rst       = 1'b0;
        bus.start = 1'b0;
        step();
        chk("post_rst_busy", 32'(bus.busy), 32'h0);

        // Additions.
        launch(16'h0001, 16'h0000, 1'b0, 1'b0);
        chk("add1_busy", 32'(bus.busy), 32'h1);
        wait_done(1, cyc);
        check_result("add1", cyc, 16'h0001, 1'b0, 1'b0);
        step();
        chk("idle_ready", 32'(bus.ready), 32'h1);
        chk("idle_hold_sum", 32'(bus.sum), 32'h0001);

        launch(16'h0B2D, 16'h0464, 1'b1, 1'b0);
        wait_done(1, cyc);
        check_result("add_cin", cyc, 16'h0F92, 1'b0, 1'b0);
        step();

        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(1, cyc);
        check_result("ripple", cyc, 16'h0000, 1'b1, 1'b0);
        step();

        launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_done(1, cyc);
        check_result("add_ovf", cyc, 16'h8000, 1'b0, 1'b1);
        step();

        // Subtractions (cin must be ignored).
        launch(16'h0005, 16'h0003, 1'b0, 1'b1);
        wait_done(1, cyc);
        check_result("sub_pos", cyc, 16'h0002, 1'b1, 1'b0);
        step();

        launch(16'h0003, 16'h0005, 1'b1, 1'b1);
        wait_done(1, cyc);
        check_result("sub_neg", cyc, 16'hFFFE, 1'b0, 1'b0);
        step();

        launch(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_done(1, cyc);
        check_result("sub_ovf", cyc, 16'h7FFF, 1'b1, 1'b1);
        step();

        // start pulsed in RUN cycle 2 with new operands: ignored.
        launch(16'h0005, 16'h0003, 1'b0, 1'b0);
        step();
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        bus.sub   = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(3, cyc);
        check_result("ign_start", cyc, 16'h0008, 1'b0, 1'b0);
        step();

        // Back-to-back: start held in the DONE cycle.
        launch(16'h0001, 16'h0002, 1'b0, 1'b0);
        wait_done(1, cyc);
        check_result("b2b_first", cyc, 16'h0003, 1'b0, 1'b0);
        chk("b2b_ready_in_done", 32'(bus.ready), 32'h1);
        launch(16'h1000, 16'h0100, 1'b0, 1'b0);
        chk("b2b_busy", 32'(bus.busy), 32'h1);
        wait_done(1, cyc);
        check_result("b2b_second", cyc, 16'h1100, 1'b0, 1'b0);
        step();

        // Reset during RUN cycle 3.
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_sum", 32'(bus.sum), 32'h0);
        chk("mid_rst_cout", 32'(bus.cout), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            step();
        end
        chk("mid_rst_no_done", 32'(saw_done), 32'h0);

        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done(1, cyc);
        check_result("after_rst", cyc, 16'h5555, 1'b0, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
